// File: rtl/bp_pkg.sv
// Shared types and constants for the branch prediction queue.
// Optional statistics are enabled with the BPQ_STATS_EN macro.
package bp_pkg;

    localparam int unsigned BP_DEPTH      = 8;
    localparam int unsigned BP_GHR_W      = 12;
    localparam int unsigned BP_ADDR_W     = 32;
    // Fall-through fetch address is branch pc plus instruction and delay slot.
    localparam int unsigned BP_SEQ_OFFSET = 8;
    localparam int unsigned BP_STAT_W     = 32;

    // One in-flight prediction.
    typedef struct packed {
        logic                 taken;
        logic [BP_GHR_W-1:0]  ghr;
        logic [BP_ADDR_W-1:0] pc;
        logic [BP_ADDR_W-1:0] target;
    } bpq_entry_t;

endpackage : bp_pkg

// File: rtl/branch_pred_queue_if.sv
// Fetch/execute-facing bus of the branch prediction queue.
// Statistics signals exist only when BPQ_STATS_EN is defined.
interface branch_pred_queue_if #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned GHR_W  = 12,
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              Push_valid;
    logic              Push_taken;
    logic [GHR_W-1:0]  Push_ghr;
    logic [ADDR_W-1:0] Push_pc;
    logic [ADDR_W-1:0] Push_target;
    logic              Push_ready;
    logic              Resolve_valid;
    logic              Resolve_taken;
    logic [ADDR_W-1:0] Resolve_target;
    logic              Flush;
    logic              Update_valid;
    logic              Update_taken;
    logic [GHR_W-1:0]  Update_ghr;
    logic              Mispredict;
    logic [ADDR_W-1:0] Redirect_addr;
    logic [CNT_W-1:0]  Count;
    logic              Empty;
    logic              Full;
    logic              Overflow;
    logic              Underflow;
`ifdef BPQ_STATS_EN
    logic [31:0]       Stat_resolved;
    logic [31:0]       Stat_mispredict;
`endif

    // Pipeline side: drives pushes, resolves and flushes.
    modport master (
        output Push_valid, Push_taken, Push_ghr, Push_pc, Push_target,
        output Resolve_valid, Resolve_taken, Resolve_target, Flush,
        input  Push_ready, Update_valid, Update_taken, Update_ghr,
        input  Mispredict, Redirect_addr, Count, Empty, Full,
        input  Overflow, Underflow
`ifdef BPQ_STATS_EN
        , input Stat_resolved, Stat_mispredict
`endif
    );

    // Queue side.
    modport slave (
        input  Push_valid, Push_taken, Push_ghr, Push_pc, Push_target,
        input  Resolve_valid, Resolve_taken, Resolve_target, Flush,
        output Push_ready, Update_valid, Update_taken, Update_ghr,
        output Mispredict, Redirect_addr, Count, Empty, Full,
        output Overflow, Underflow
`ifdef BPQ_STATS_EN
        , output Stat_resolved, Stat_mispredict
`endif
    );

endinterface : branch_pred_queue_if

// File: rtl/bpq_fifo_mem.sv
// Entry storage for the branch prediction queue: one write port,
// asynchronous read at the read pointer. Contents are not reset.
module bpq_fifo_mem
    import bp_pkg::*;
#(
    parameter  int unsigned DEPTH = BP_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [PTR_W-1:0] wr_addr_i,
    input  bpq_entry_t       wr_data_i,
    input  logic [PTR_W-1:0] rd_addr_i,
    output bpq_entry_t       rd_data_c_o
);

    bpq_entry_t mem_q [DEPTH];

    // Write accepted entry.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_c_o = mem_q[rd_addr_i];

endmodule : bpq_fifo_mem

// File: rtl/branch_pred_queue.sv
// In-flight branch prediction tracker: queues predictions from fetch,
// checks them against execute resolution in order, and emits a
// registered predictor update plus mispredict/redirect.
// Optional macro BPQ_STATS_EN adds resolve/mispredict counters.
module branch_pred_queue
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH  = BP_DEPTH,
    parameter int unsigned GHR_W  = BP_GHR_W,
    parameter int unsigned ADDR_W = BP_ADDR_W
) (
    input  logic CLK,
    input  logic RESET,
    branch_pred_queue_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              upd_valid_q, upd_valid_d;
    logic              upd_taken_q, upd_taken_d;
    logic [GHR_W-1:0]  upd_ghr_q, upd_ghr_d;
    logic              mispred_q, mispred_d;
    logic [ADDR_W-1:0] redirect_q, redirect_d;

    logic              push_acc;
    logic              pop;
    logic              mis_c;
    logic [ADDR_W-1:0] redirect_c;
    bpq_entry_t        wr_entry;
    bpq_entry_t        rd_entry;

    assign wr_entry.taken  = bus.Push_taken;
    assign wr_entry.ghr    = BP_GHR_W'(bus.Push_ghr);
    assign wr_entry.pc     = BP_ADDR_W'(bus.Push_pc);
    assign wr_entry.target = BP_ADDR_W'(bus.Push_target);

    bpq_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk         (CLK),
        .wr_en_i     (push_acc),
        .wr_addr_i   (wr_ptr_q),
        .wr_data_i   (wr_entry),
        .rd_addr_i   (rd_ptr_q),
        .rd_data_c_o (rd_entry)
    );

    // Next-state: pointer/occupancy bookkeeping and resolution compare.
    always_comb begin
        push_acc    = bus.Push_valid && !full_q && !bus.Flush;
        pop         = bus.Resolve_valid && !empty_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        upd_valid_d = pop;
        upd_taken_d = upd_taken_q;
        upd_ghr_d   = upd_ghr_q;
        mispred_d   = 1'b0;
        redirect_d  = '0;

        mis_c = (rd_entry.taken != bus.Resolve_taken) ||
                (bus.Resolve_taken &&
                 (ADDR_W'(rd_entry.target) != bus.Resolve_target));
        redirect_c = bus.Resolve_taken ? bus.Resolve_target
                   : ADDR_W'(rd_entry.pc) + ADDR_W'(BP_SEQ_OFFSET);

        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            upd_taken_d = bus.Resolve_taken;
            upd_ghr_d   = GHR_W'(rd_entry.ghr);
            mispred_d   = mis_c;
            redirect_d  = mis_c ? redirect_c : '0;
        end
        count_d = count_q + CNT_W'(push_acc) - CNT_W'(pop);

        // Flush wins over pointer movement; the pop's update still goes out.
        if (bus.Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        empty_d     = (count_d == '0);
        full_d      = (count_d == CNT_W'(DEPTH));
        overflow_d  = overflow_q  | (bus.Push_valid & full_q & ~bus.Flush);
        underflow_d = underflow_q | (bus.Resolve_valid & empty_q);
    end

    // State and registered outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            upd_valid_q <= 1'b0;
            upd_taken_q <= 1'b0;
            upd_ghr_q   <= '0;
            mispred_q   <= 1'b0;
            redirect_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            upd_valid_q <= upd_valid_d;
            upd_taken_q <= upd_taken_d;
            upd_ghr_q   <= upd_ghr_d;
            mispred_q   <= mispred_d;
            redirect_q  <= redirect_d;
        end
    end

    assign bus.Push_ready    = ~full_q;
    assign bus.Update_valid  = upd_valid_q;
    assign bus.Update_taken  = upd_taken_q;
    assign bus.Update_ghr    = upd_ghr_q;
    assign bus.Mispredict    = mispred_q;
    assign bus.Redirect_addr = redirect_q;
    assign bus.Count         = count_q;
    assign bus.Empty         = empty_q;
    assign bus.Full          = full_q;
    assign bus.Overflow      = overflow_q;
    assign bus.Underflow     = underflow_q;

`ifdef BPQ_STATS_EN
    logic [BP_STAT_W-1:0] stat_res_q;
    logic [BP_STAT_W-1:0] stat_mis_q;

    // Saturating counters, advancing on the edge that launches each pulse.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stat_res_q <= '0;
            stat_mis_q <= '0;
        end else begin
            if (upd_valid_d && (stat_res_q != '1)) begin
                stat_res_q <= stat_res_q + BP_STAT_W'(1);
            end
            if (mispred_d && (stat_mis_q != '1)) begin
                stat_mis_q <= stat_mis_q + BP_STAT_W'(1);
            end
            if (mispred_d) begin
                $display("bpq mispredict: pc=0x%08h ghr=0x%0h redirect=0x%08h",
                         rd_entry.pc, rd_entry.ghr, redirect_d);
            end
        end
    end

    assign bus.Stat_resolved   = stat_res_q;
    assign bus.Stat_mispredict = stat_mis_q;
`endif

endmodule : branch_pred_queue

// File: tb/tb_branch_pred_queue.sv
// Scoreboard bench for branch_pred_queue: stimulus queues expected
// updates, a negedge monitor pops and compares them.
module tb_branch_pred_queue;
    import bp_pkg::*;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned GHR_W  = 12;
    localparam int unsigned ADDR_W = 32;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    always #5 CLK = ~CLK;

    branch_pred_queue_if #(.DEPTH(DEPTH), .GHR_W(GHR_W), .ADDR_W(ADDR_W)) bus ();

    branch_pred_queue #(.DEPTH(DEPTH), .GHR_W(GHR_W), .ADDR_W(ADDR_W)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct {
        logic              taken;
        logic [GHR_W-1:0]  ghr;
        logic              mis;
        logic [ADDR_W-1:0] redir;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic step();
        tick();
        bus.Push_valid    = 1'b0;
        bus.Resolve_valid = 1'b0;
        bus.Flush         = 1'b0;
    endtask

    task automatic set_push(input logic t, input logic [GHR_W-1:0] g,
                            input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] tgt);
        bus.Push_valid  = 1'b1;
        bus.Push_taken  = t;
        bus.Push_ghr    = g;
        bus.Push_pc     = pc;
        bus.Push_target = tgt;
    endtask

    // Drive a resolve; when a pop is expected, queue the hand-computed update.
    task automatic set_resolve(input logic t, input logic [ADDR_W-1:0] tgt,
                               input logic exp_pop, input logic [GHR_W-1:0] g,
                               input logic mis, input logic [ADDR_W-1:0] rd);
        exp_t e;
        bus.Resolve_valid  = 1'b1;
        bus.Resolve_taken  = t;
        bus.Resolve_target = tgt;
        if (exp_pop) begin
            e.taken = t;
            e.ghr   = g;
            e.mis   = mis;
            e.redir = rd;
            sb.push_back(e);
        end
    endtask

    // Monitor: every update pulse must match the oldest expected entry.
    always @(negedge CLK) begin
        if (bus.Update_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_update", 64'(bus.Update_valid), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("update_taken", 64'(bus.Update_taken), 64'(mon_e.taken));
                chk("update_ghr", 64'(bus.Update_ghr), 64'(mon_e.ghr));
                chk("mispredict", 64'(bus.Mispredict), 64'(mon_e.mis));
                chk("redirect_addr", 64'(bus.Redirect_addr), 64'(mon_e.redir));
            end
        end else begin
            chk("mispredict_idle", 64'(bus.Mispredict), 64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.Push_valid     = 1'b0;
        bus.Push_taken     = 1'b0;
        bus.Push_ghr       = '0;
        bus.Push_pc        = '0;
        bus.Push_target    = '0;
        bus.Resolve_valid  = 1'b0;
        bus.Resolve_taken  = 1'b0;
        bus.Resolve_target = '0;
        bus.Flush          = 1'b0;

        // Reset values
        tick();
        tick();
        chk("rst_count", 64'(bus.Count), 64'd0);
        chk("rst_empty", 64'(bus.Empty), 64'd1);
        chk("rst_full", 64'(bus.Full), 64'd0);
        chk("rst_push_ready", 64'(bus.Push_ready), 64'd1);
        chk("rst_update_valid", 64'(bus.Update_valid), 64'd0);
        chk("rst_update_ghr", 64'(bus.Update_ghr), 64'd0);
        chk("rst_redirect", 64'(bus.Redirect_addr), 64'd0);
        chk("rst_overflow", 64'(bus.Overflow), 64'd0);
        chk("rst_underflow", 64'(bus.Underflow), 64'd0);
        RESET = 1'b1;
        tick();

        // Correct taken prediction
        set_push(1'b1, 12'h0A5, 32'h0040_0100, 32'h0040_0200);
        step();
        chk("one_entry_count", 64'(bus.Count), 64'd1);
        chk("one_entry_empty", 64'(bus.Empty), 64'd0);
        set_resolve(1'b1, 32'h0040_0200, 1'b1, 12'h0A5, 1'b0, 32'h0);
        step();
        chk("after_pop_empty", 64'(bus.Empty), 64'd1);

        // Direction and target mispredicts, and pc+8 wrap
        set_push(1'b1, 12'h011, 32'h0040_0040, 32'h0040_0080);
        step();
        set_resolve(1'b0, 32'h0, 1'b1, 12'h011, 1'b1, 32'h0040_0048);
        step();
        set_push(1'b1, 12'h022, 32'h0000_1000, 32'h0000_2000);
        step();
        set_resolve(1'b1, 32'h0000_3000, 1'b1, 12'h022, 1'b1, 32'h0000_3000);
        step();
        set_push(1'b0, 12'h033, 32'hFFFF_FFFC, 32'h0);
        step();
        set_resolve(1'b1, 32'h0000_5000, 1'b1, 12'h033, 1'b1, 32'h0000_5000);
        step();
        set_push(1'b0, 12'h044, 32'hFFFF_FFFC, 32'h0);
        step();
        set_resolve(1'b0, 32'h0, 1'b1, 12'h044, 1'b0, 32'h0);
        step();
        set_push(1'b1, 12'h055, 32'hFFFF_FFFC, 32'h0000_0010);
        step();
        set_resolve(1'b0, 32'h0, 1'b1, 12'h055, 1'b1, 32'h0000_0004);
        step();

        // Fill to full (pointers start at 6, so this wraps), then overflow
        for (int i = 0; i < 8; i++) begin
            set_push(1'(i & 1), GHR_W'(i), ADDR_W'(32'h100 * i), ADDR_W'(32'h8000 + i));
            step();
        end
        chk("full_count", 64'(bus.Count), 64'd8);
        chk("full_flag", 64'(bus.Full), 64'd1);
        chk("full_push_ready", 64'(bus.Push_ready), 64'd0);
        chk("full_no_overflow_yet", 64'(bus.Overflow), 64'd0);
        set_push(1'b1, 12'h0FF, 32'h0000_0F00, 32'h0000_0F80);
        step();
        chk("overflow_set", 64'(bus.Overflow), 64'd1);
        chk("overflow_count", 64'(bus.Count), 64'd8);
        for (int i = 0; i < 8; i++) begin
            set_resolve(1'(i & 1), ADDR_W'(32'h8000 + i), 1'b1, GHR_W'(i), 1'b0, 32'h0);
            step();
        end
        chk("drained_empty", 64'(bus.Empty), 64'd1);
        chk("drained_count", 64'(bus.Count), 64'd0);

        // Refill three, then simultaneous push+pop at Count=3
        for (int i = 0; i < 3; i++) begin
            set_push(1'b1, GHR_W'(32'h10 + i), ADDR_W'(32'h700 + i), ADDR_W'(32'h9000 + i));
            step();
        end
        chk("refill_count", 64'(bus.Count), 64'd3);
        set_push(1'b1, 12'h013, 32'h0000_0703, 32'h0000_9003);
        set_resolve(1'b1, 32'h0000_9000, 1'b1, 12'h010, 1'b0, 32'h0);
        step();
        chk("push_pop_count", 64'(bus.Count), 64'd3);
        for (int i = 1; i < 4; i++) begin
            set_resolve(1'b1, ADDR_W'(32'h9000 + i), 1'b1, GHR_W'(32'h10 + i), 1'b0, 32'h0);
            step();
        end
        chk("refill_drained", 64'(bus.Empty), 64'd1);

        // Resolve on empty, and same-cycle push into empty (no bypass)
        set_resolve(1'b0, 32'h0, 1'b0, 12'h0, 1'b0, 32'h0);
        step();
        chk("underflow_set", 64'(bus.Underflow), 64'd1);
        chk("underflow_count", 64'(bus.Count), 64'd0);
        set_push(1'b0, 12'h020, 32'h0000_0800, 32'h0);
        set_resolve(1'b0, 32'h0, 1'b0, 12'h0, 1'b0, 32'h0);
        step();
        chk("no_bypass_count", 64'(bus.Count), 64'd1);
        set_resolve(1'b0, 32'h0, 1'b1, 12'h020, 1'b0, 32'h0);
        step();
        chk("no_bypass_drained", 64'(bus.Empty), 64'd1);
        chk("overflow_sticky", 64'(bus.Overflow), 64'd1);

        // Async reset between edges while an update pulse is showing
        set_push(1'b0, 12'h021, 32'h0000_0810, 32'h0);
        step();
        set_push(1'b0, 12'h022, 32'h0000_0820, 32'h0);
        step();
        bus.Resolve_valid = 1'b1;
        bus.Resolve_taken = 1'b0;
        step();
        chk("pre_reset_update_valid", 64'(bus.Update_valid), 64'd1);
        chk("pre_reset_count", 64'(bus.Count), 64'd1);
        #2;
        RESET = 1'b0;
        #1;
        chk("async_rst_count", 64'(bus.Count), 64'd0);
        chk("async_rst_update_valid", 64'(bus.Update_valid), 64'd0);
        chk("async_rst_empty", 64'(bus.Empty), 64'd1);
        chk("async_rst_overflow", 64'(bus.Overflow), 64'd0);
        chk("async_rst_underflow", 64'(bus.Underflow), 64'd0);
        #3;
        RESET = 1'b1;
        tick();

        // Flush at Count=4 with resolve and push in the same cycle
        for (int i = 0; i < 4; i++) begin
            set_push(1'b0, GHR_W'(32'h30 + i), ADDR_W'(32'hA00 + i), 32'h0);
            step();
        end
        chk("pre_flush_count", 64'(bus.Count), 64'd4);
        set_push(1'b1, 12'h03F, 32'h0000_0AF0, 32'h0000_0BF0);
        set_resolve(1'b0, 32'h0, 1'b1, 12'h030, 1'b0, 32'h0);
        bus.Flush = 1'b1;
        step();
        chk("flush_count", 64'(bus.Count), 64'd0);
        chk("flush_empty", 64'(bus.Empty), 64'd1);
        chk("flush_overflow", 64'(bus.Overflow), 64'd0);
        set_push(1'b1, 12'h040, 32'h0000_0B00, 32'h0000_0C00);
        step();
        set_resolve(1'b1, 32'h0000_0C00, 1'b1, 12'h040, 1'b0, 32'h0);
        step();

        // Three more resolves, two of them mispredicted
        set_push(1'b1, 12'h041, 32'h0000_0B10, 32'h0000_0C10);
        step();
        set_resolve(1'b0, 32'h0, 1'b1, 12'h041, 1'b1, 32'h0000_0B18);
        step();
        set_push(1'b0, 12'h042, 32'h0000_0B20, 32'h0);
        step();
        set_resolve(1'b0, 32'h0, 1'b1, 12'h042, 1'b0, 32'h0);
        step();
        set_push(1'b1, 12'h043, 32'h0000_0B30, 32'h0000_0C30);
        step();
        set_resolve(1'b1, 32'h0000_0D30, 1'b1, 12'h043, 1'b1, 32'h0000_0D30);
        step();
        tick();
`ifdef BPQ_STATS_EN
        chk("stat_resolved", 64'(bus.Stat_resolved), 64'd5);
        chk("stat_mispredict", 64'(bus.Stat_mispredict), 64'd2);
`endif
        tick();
        tick();
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_branch_pred_queue

// File: doc/branch_pred_queue.md
Name: branch_pred_queue

Overview:
- In-flight prediction tracker between fetch-stage predictor output and execute-stage branch resolution.
- Each predicted branch is pushed with its predicted direction, the GHR snapshot used for the PHT lookup, its PC and its predicted target.
- On resolution, the oldest entry is popped and compared with the actual outcome.
- Produces a registered predictor update (direction and GHR index) plus mispredict and redirect signals for fetch.

Parameters:
DEPTH, 8, entry count; power of 2, at least 2
GHR_W, 12, width of stored global history snapshot
ADDR_W, 32, PC/target width

Ports:
CLK  in  1  clock
RESET  in  1  asynchronous, active-low reset
Push_valid  in  1  fetch has a predicted conditional branch this cycle
Push_taken  in  1  predicted direction
Push_ghr  in  GHR_W  GHR value used to index PHT
Push_pc  in  ADDR_W  branch instruction address
Push_target  in  ADDR_W  predicted taken target
Push_ready  out  1  equals !Full (combinational)
Resolve_valid  in  1  execute resolved oldest branch
Resolve_taken  in  1  actual direction
Resolve_target  in  ADDR_W  actual taken target
Flush  in  1  discard all entries
Update_valid  out  1  one-cycle pulse: predictor update
Update_taken  out  1  actual direction for counter update
Update_ghr  out  GHR_W  PHT index to update
Mispredict  out  1  one-cycle pulse, coincident with Update_valid
Redirect_addr  out  ADDR_W  correct fetch address when Mispredict=1
Count  out  $clog2(DEPTH)+1  occupancy
Empty  out  1  Count==0
Full  out  1  Count==DEPTH
Overflow  out  1  sticky: push attempted while full
Underflow  out  1  sticky: resolve attempted while empty

Behaviour:
- Storage is a circular buffer with rd_ptr/wr_ptr of width $clog2(DEPTH); pointers wrap modulo DEPTH.
- Reset values:
  - Pointers, Count, Update_valid, Update_taken, Update_ghr, Mispredict, Redirect_addr, Overflow and Underflow are all 0.
  - Empty=1, Full=0.
  - Entry contents are don't-care.
- Push:
  - Accepted when Push_valid && !Full; the entry is written at wr_ptr and wr_ptr increments.
  - Push_valid && Full: entry dropped, Overflow set.
  - A push is never accepted into a full queue, even if a pop happens in the same cycle.
- Resolve:
  - When Resolve_valid && !Empty, the entry at rd_ptr is popped and the update outputs are registered at the next CLK edge (1-cycle latency).
  - Update_taken = Resolve_taken; Update_ghr = entry ghr.
  - Mispredict = (entry taken != Resolve_taken) || (Resolve_taken && entry target != Resolve_target).
  - Redirect_addr = Resolve_target if Resolve_taken, else entry pc + 8 (skips delay slot, 32-bit wrap); it is 0 when not mispredicting.
  - Resolve_valid && Empty: no pop, no update, Underflow set.
  - A same-cycle push into an empty queue is not bypassed.
- Simultaneous push and pop when 0<Count<DEPTH: both happen, Count unchanged.
- Flush:
  - Next cycle, pointers and Count are 0.
  - A resolve in the same cycle is still processed (the update is emitted); a push in the same cycle is dropped without setting Overflow.
- Update_valid and Mispredict deassert the cycle after their pulse unless another resolve follows.
- Overflow and Underflow clear only on RESET.
- RESET mid-operation clears everything immediately (async) and discards all entries.

Optional Feature:
- Macro: BPQ_STATS_EN.
- When defined:
  - Adds 32-bit output counters Stat_resolved and Stat_mispredict, reset to 0.
  - Each increments on every emitted Update_valid / Mispredict pulse and saturates at 0xFFFFFFFF.
  - Adds a $display on each mispredict showing pc, GHR and redirect.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package, bp_pkg:
  - GHR_W default and ADDR_W.
  - bpq_entry_t struct {taken, ghr, pc, target}.
  - Delay-slot offset constant BP_SEQ_OFFSET = 8.
- One natural sub-module, bpq_fifo_mem: the DEPTH-entry register array with a write port and async read at rd_ptr. Control and compare logic stay in branch_pred_queue.

Test Plan:
- Reset, then push {taken=1, ghr=0x0A5, pc=0x400100, target=0x400200}; resolve taken, target=0x400200 -> next cycle Update_valid=1, Update_ghr=0x0A5, Update_taken=1, Mispredict=0, Empty=1.
- Push {taken=1, pc=0x400040}; resolve not-taken -> Mispredict=1, Redirect_addr=0x400048, Update_taken=0.
- Push 8 entries -> Full=1, Push_ready=0; 9th push -> dropped, Overflow=1, Count=8; then 8 resolves -> pops in push order (ghr 0..7), wrap correct on a refill of 3 more.
- Resolve on empty -> no Update_valid, Underflow=1; simultaneous push+resolve at Count=3 -> Count stays 3.
- Count=4, Flush with Resolve_valid and Push_valid -> Update_valid pulse for oldest, Count=0 next cycle, Overflow=0.
- Async RESET asserted mid-stream between clock edges -> Count=0, Update_valid=0 immediately; with BPQ_STATS_EN, 5 resolves incl. 2 mispredicts -> Stat_resolved=5, Stat_mispredict=2.
